// File: rtl/dac_pkg.sv
// Shared types and defaults for the PWM DAC driver and its helpers.
package dac_pkg;

  localparam int DAC_WIDTH = 8;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_SETTLING = 2'd1,
    S_SETTLED  = 2'd2
  } state_t;

endpackage

// File: rtl/pwm_tick_gen.sv
// Prescaler: one tick every PRESCALE clocks while i_run is high, held at zero otherwise.
module pwm_tick_gen
  import dac_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_run,
  output logic o_tick
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] r_cnt;
  logic          w_last;

  assign w_last = (r_cnt == LAST);
  assign o_tick = i_run && w_last;

  always_ff @(posedge i_clk) begin
    if (i_reset || !i_run) begin
      r_cnt <= '0;
    end else if (w_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pwm_dac_driver.sv
// PWM renderer for the SAR DAC code: one-deep pending slot, period-aligned loads, settle tracking.
//   state      | meaning
//   S_IDLE     | disabled; counters held at 0, pwm low, not settled
//   S_SETTLING | running; counting unloaded periods since last load / enable
//   S_SETTLED  | running; RC output trustworthy, dac_settled high
module pwm_dac_driver
  import dac_pkg::*;
#(
  parameter int WIDTH          = DAC_WIDTH,
  parameter int PRESCALE       = 1,
  parameter int SETTLE_PERIODS = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_enable,
  input  logic [WIDTH-1:0] i_code_in,
  input  logic             i_code_valid,
  output logic             o_code_ready,
  output logic             o_pwm_out,
  output logic [WIDTH-1:0] o_active_code,
  output logic             o_period_start,
  output logic             o_dac_settled
);

  localparam int SW = $clog2(SETTLE_PERIODS + 1);
  localparam logic [WIDTH-1:0] CNT_MAX     = '1;
  localparam logic [SW-1:0]    SETTLE_LAST = SW'(SETTLE_PERIODS - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_pwm_cnt;
  logic [WIDTH-1:0] r_pending;
  logic             r_pending_valid;
  logic [WIDTH-1:0] r_active_code;
  logic [SW-1:0]    r_settle_cnt;
  logic             r_pwm_out;
  logic             r_period_start;
  logic             r_dac_settled;

  state_t           w_state_next;
  logic             w_run;
  logic             w_tick;
  logic             w_boundary;
  logic             w_accept;
  logic             w_load;
  logic [WIDTH-1:0] w_pwm_cnt_next;
  logic [WIDTH-1:0] w_pending_next;
  logic             w_pending_valid_next;
  logic [WIDTH-1:0] w_active_next;
  logic [SW-1:0]    w_settle_next;
  logic             w_settled_next;
  logic             w_pwm_out_next;

  // The run qualifier already folds in enable so a falling enable freezes everything at once.
  assign w_run        = (r_state != S_IDLE) && i_enable;
  assign o_code_ready = i_enable && !r_pending_valid;
  assign w_accept     = i_code_valid && o_code_ready;
  assign w_boundary   = w_tick && (r_pwm_cnt == CNT_MAX);
  assign w_load       = w_boundary && r_pending_valid;

  pwm_tick_gen #(
    .PRESCALE(PRESCALE)
  ) u_tick_gen (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .i_run  (w_run),
    .o_tick (w_tick)
  );

  always_comb begin
    w_state_next         = r_state;
    w_pwm_cnt_next       = r_pwm_cnt;
    w_pending_next       = r_pending;
    w_pending_valid_next = r_pending_valid;
    w_active_next        = r_active_code;
    w_settle_next        = r_settle_cnt;
    w_settled_next       = r_dac_settled;

    if (!w_run) begin
      w_pwm_cnt_next = '0;
    end else if (w_tick) begin
      w_pwm_cnt_next = r_pwm_cnt + 1'b1;
    end

    if (w_accept) begin
      w_pending_next       = i_code_in;
      w_pending_valid_next = 1'b1;
    end

    if (w_load) begin
      w_active_next        = r_pending;
      w_pending_valid_next = 1'b0;
    end

    case (r_state)
      S_IDLE: begin
        w_settle_next  = '0;
        w_settled_next = 1'b0;
        if (i_enable) begin
          w_state_next = S_SETTLING;
        end
      end
      S_SETTLING: begin
        if (w_load) begin
          w_settle_next  = '0;
          w_settled_next = 1'b0;
        end else if (w_boundary) begin
          if (r_settle_cnt == SETTLE_LAST) begin
            w_state_next   = S_SETTLED;
            w_settled_next = 1'b1;
          end else begin
            w_settle_next = r_settle_cnt + 1'b1;
          end
        end
      end
      S_SETTLED: begin
        if (w_load) begin
          w_state_next   = S_SETTLING;
          w_settle_next  = '0;
          w_settled_next = 1'b0;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase

    // Disable from a run state drops any queued code; active_code survives for re-enable.
    if ((r_state != S_IDLE) && !i_enable) begin
      w_state_next         = S_IDLE;
      w_pending_valid_next = 1'b0;
      w_settle_next        = '0;
      w_settled_next       = 1'b0;
    end

    w_pwm_out_next = (w_state_next != S_IDLE) && (w_pwm_cnt_next < w_active_next);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state         <= S_IDLE;
      r_pwm_cnt       <= '0;
      r_pending       <= '0;
      r_pending_valid <= 1'b0;
      r_active_code   <= '0;
      r_settle_cnt    <= '0;
      r_pwm_out       <= 1'b0;
      r_period_start  <= 1'b0;
      r_dac_settled   <= 1'b0;
    end else begin
      r_state         <= w_state_next;
      r_pwm_cnt       <= w_pwm_cnt_next;
      r_pending       <= w_pending_next;
      r_pending_valid <= w_pending_valid_next;
      r_active_code   <= w_active_next;
      r_settle_cnt    <= w_settle_next;
      r_pwm_out       <= w_pwm_out_next;
      r_period_start  <= w_boundary;
      r_dac_settled   <= w_settled_next;
    end
  end

  assign o_pwm_out      = r_pwm_out;
  assign o_active_code  = r_active_code;
  assign o_period_start = r_period_start;
  assign o_dac_settled  = r_dac_settled;

endmodule
